// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional performance counters are enabled with the HAZ_PERF_CNT_EN macro.
package hazard_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } hz_state_t;

    localparam int unsigned MD_LATENCY_DEF = 4;
    localparam int unsigned PERF_CNT_W     = 32;
    localparam int unsigned MD_CNT_W       = 4;

endpackage

// File: rtl/hazard_perf_counters.sv
// Saturating hazard event counters; present only when HAZ_PERF_CNT_EN is defined.
module hazard_perf_counters
    import hazard_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_use_evt,
    input  logic                  md_stall_evt,
    input  logic                  flush_evt,
    output logic [PERF_CNT_W-1:0] load_use_cnt,
    output logic [PERF_CNT_W-1:0] md_stall_cnt,
    output logic [PERF_CNT_W-1:0] flush_cnt
);

    always_ff @(posedge clk) begin
        if (reset) begin
            load_use_cnt <= '0;
            md_stall_cnt <= '0;
            flush_cnt    <= '0;
        end else begin
            // each counter sticks at all-ones instead of wrapping
            if (load_use_evt && (load_use_cnt != '1))
                load_use_cnt <= load_use_cnt + 1'b1;
            if (md_stall_evt && (md_stall_cnt != '1))
                md_stall_cnt <= md_stall_cnt + 1'b1;
            if (flush_evt && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, multi-cycle mul/div EX occupancy.
// Defining HAZ_PERF_CNT_EN adds the LoadUseCnt/MdStallCnt/FlushCnt performance outputs.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MD_LATENCY = MD_LATENCY_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4:0]            Rs1D,
    input  logic [4:0]            Rs2D,
    input  logic [4:0]            RdE,
    input  logic                  ResultSrcE0,
    input  logic                  PCSrcE,
    input  logic                  MdStartE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  FlushM,
    output logic                  MdBusy,
    output logic                  MdDoneE
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] LoadUseCnt,
    output logic [PERF_CNT_W-1:0] MdStallCnt,
    output logic [PERF_CNT_W-1:0] FlushCnt
`endif
);

    // The start cycle counts as one EX cycle and the done cycle as another.
    localparam logic [MD_CNT_W-1:0] CNT_LOAD = MD_CNT_W'(MD_LATENCY - 2);

    hz_state_t           state;
    hz_state_t           state_nxt;
    logic [MD_CNT_W-1:0] cnt;
    logic [MD_CNT_W-1:0] cnt_nxt;
    logic                load_use;
    logic                md_start;

    assign load_use = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    // A taken branch kills the EX instruction, so it cannot start a mul/div.
    assign md_start = MdStartE && !PCSrcE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (md_start) begin
                    state_nxt = BUSY;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt != '0)
                    cnt_nxt = cnt - 1'b1;
                else
                    state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        StallF  = 1'b0;
        StallD  = 1'b0;
        StallE  = 1'b0;
        FlushD  = 1'b0;
        FlushE  = 1'b0;
        FlushM  = 1'b0;
        MdBusy  = 1'b0;
        MdDoneE = 1'b0;
        if (!reset) begin
            unique case (state)
                IDLE: begin
                    FlushD = PCSrcE;
                    // the mul/div being started must never be bubbled out of EX
                    FlushE = PCSrcE || (load_use && !md_start);
                    StallF = load_use || md_start;
                    StallD = load_use || md_start;
                    StallE = md_start;
                    FlushM = md_start;
                end
                BUSY: begin
                    MdBusy = 1'b1;
                    if (cnt != '0) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        StallE = 1'b1;
                        FlushM = 1'b1;
                    end else begin
                        MdDoneE = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic load_use_evt;
    logic md_stall_evt;
    logic flush_evt;

    // StallD without StallE only arises from a load-use hazard in IDLE.
    assign load_use_evt = StallD && !StallE;
    assign md_stall_evt = StallE;
    assign flush_evt    = FlushD;

    hazard_perf_counters u_perf (
        .clk          (clk),
        .reset        (reset),
        .load_use_evt (load_use_evt),
        .md_stall_evt (md_stall_evt),
        .flush_evt    (flush_evt),
        .load_use_cnt (LoadUseCnt),
        .md_stall_cnt (MdStallCnt),
        .flush_cnt    (FlushCnt)
    );
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl with MD_LATENCY=4; counter checks when HAZ_PERF_CNT_EN is defined.
module tb_pipe_hazard_ctrl;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } item_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, RdE;
    logic       ResultSrcE0, PCSrcE, MdStartE;
    logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy, MdDoneE;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] LoadUseCnt, MdStallCnt, FlushCnt;
`endif

    item_t sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MD_LATENCY(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .RdE         (RdE),
        .ResultSrcE0 (ResultSrcE0),
        .PCSrcE      (PCSrcE),
        .MdStartE    (MdStartE),
        .StallF      (StallF),
        .StallD      (StallD),
        .StallE      (StallE),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .FlushM      (FlushM),
        .MdBusy      (MdBusy),
        .MdDoneE     (MdDoneE)
`ifdef HAZ_PERF_CNT_EN
        ,
        .LoadUseCnt  (LoadUseCnt),
        .MdStallCnt  (MdStallCnt),
        .FlushCnt    (FlushCnt)
`endif
    );

    // Output vector order: {StallF,StallD,StallE,FlushD,FlushE,FlushM,MdBusy,MdDoneE}
    localparam logic [7:0] NONE  = 8'b0000_0000;
    localparam logic [7:0] LU    = 8'b1100_1000;
    localparam logic [7:0] BR    = 8'b0001_1000;
    localparam logic [7:0] MDST  = 8'b1110_0100;
    localparam logic [7:0] MDBSY = 8'b1110_0110;
    localparam logic [7:0] MDDN  = 8'b0000_0011;

    // Monitor: every cycle with an outstanding expectation, compare at negedge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            item_t it;
            logic [7:0] act;
            it  = sb.pop_front();
            act = {StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy, MdDoneE};
            n_cmp++;
            if (act !== it.exp) begin
                n_bad++;
                $display("FAIL %s: got %b expected %b", it.name, act, it.exp);
            end
        end
    end

    task automatic step(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic ld, input logic pc, input logic md,
                        input logic [7:0] exp, input string name);
        item_t it;
        @(posedge clk);
        #1;
        reset = rst; Rs1D = rs1; Rs2D = rs2; RdE = rd;
        ResultSrcE0 = ld; PCSrcE = pc; MdStartE = md;
        it.name = name;
        it.exp  = exp;
        sb.push_back(it);
    endtask

    task automatic idle(input string name);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NONE, name);
    endtask

    task automatic drain;
        int unsigned guard = 0;
        while (sb.size() > 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d items left expected 0", sb.size());
            sb.delete();
        end
    endtask

`ifdef HAZ_PERF_CNT_EN
    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
`endif

    initial begin
        reset = 1'b1; Rs1D = '0; Rs2D = '0; RdE = '0;
        ResultSrcE0 = 1'b0; PCSrcE = 1'b0; MdStartE = 1'b0;

        // reset holds every output low even with active hazard inputs
        step(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, NONE, "reset_a");
        step(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, NONE, "reset_b");
        idle("idle_after_reset");

        // load-use
        step(1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, LU,   "lu_rs1");
        idle("lu_one_cycle");
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, NONE, "lu_rd0");
        step(1'b0, 5'd3, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, LU,   "lu_rs2");
        step(1'b0, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, NONE, "no_load");

        // taken branch, with and without a concurrent mul/div start
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, BR,   "branch");
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, BR,   "branch_md");
        idle("branch_md_no_busy");

        // mul/div op; BUSY ignores branch and load-use
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, MDST,  "md_c0");
        step(1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, MDBSY, "md_c1");
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, MDBSY, "md_c2");
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, MDDN,  "md_c3");
        idle("md_c4_idle");

        // mul/div with concurrent load-use, then back-to-back op
        step(1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, MDST,  "md_lu_start");
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, MDBSY, "md_lu_c1");
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, MDBSY, "md_lu_c2");
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, MDDN,  "md_lu_done");
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, MDST,  "b2b_start");
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, MDBSY, "b2b_c1");
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, MDBSY, "b2b_c2");
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, MDDN,  "b2b_done");
        idle("b2b_idle");

        // reset during the second BUSY cycle aborts without MdDoneE
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, MDST,  "rst_md_start");
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, MDBSY, "rst_md_c1");
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, NONE,  "rst_md_c2");
        idle("rst_md_after_a");
        idle("rst_md_after_b");
        idle("rst_md_after_c");
        drain();

`ifdef HAZ_PERF_CNT_EN
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, NONE, "perf_reset");
        idle("perf_idle0");
        drain();
        chk32("perf_lu_reset", LoadUseCnt, 32'd0);
        chk32("perf_md_reset", MdStallCnt, 32'd0);
        chk32("perf_fl_reset", FlushCnt,   32'd0);
        step(1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, LU,    "perf_lu1");
        idle("perf_idle1");
        step(1'b0, 5'd0, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, LU,    "perf_lu2");
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, MDST,  "perf_md0");
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, MDBSY, "perf_md1");
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, MDBSY, "perf_md2");
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, MDDN,  "perf_md3");
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, BR,    "perf_br");
        idle("perf_idle2");
        drain();
        chk32("perf_lu", LoadUseCnt, 32'd2);
        chk32("perf_md", MdStallCnt, 32'd3);
        chk32("perf_fl", FlushCnt,   32'd1);
`endif

        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous active-high reset, reset; both are listed first.
REQ-002 Parameter MD_LATENCY SHALL default to 4 and give the total EX-stage occupancy in cycles of a multi-cycle mul/div op; legal range is 2..16.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 Rs1D, Rs2D  in  5 each  source register numbers in the Decode stage.
REQ-006 RdE  in  5  destination register number in the EX stage.
REQ-007 ResultSrcE0  in  1  EX instruction is a load.
REQ-008 PCSrcE  in  1  EX branch/jump taken.
REQ-009 MdStartE  in  1  EX instruction is a multi-cycle mul/div; held high while that instruction sits in EX.
REQ-010 StallF, StallD, StallE  out  1 each  hold the PC, IF/ID and ID/EX registers.
REQ-011 FlushD, FlushE, FlushM  out  1 each  bubble the IF/ID, ID/EX and EX/MEM registers.
REQ-012 MdBusy  out  1  FSM is in BUSY; MdDoneE  out  1  final mul/div cycle; result is valid in EX.

Function
REQ-013 The FSM SHALL have two states, IDLE and BUSY, plus a 4-bit down-counter cnt.
REQ-014 IDLE: PCSrcE=1 SHALL assert FlushD and FlushE; a mul/div start is not taken that cycle (PCSrcE has priority).
REQ-015 IDLE: a load-use hazard is ResultSrcE0=1 and RdE!=0 and (RdE==Rs1D or RdE==Rs2D); it SHALL assert StallF, StallD and FlushE for exactly that cycle.
REQ-016 IDLE with MdStartE=1 and PCSrcE=0: the block SHALL assert StallF, StallD, StallE and FlushM, load cnt<=MD_LATENCY-2 and go to BUSY.
REQ-017 In the REQ-016 case the load-use FlushE SHALL be suppressed, so the mul/div instruction is never killed.
REQ-018 BUSY with cnt!=0: assert StallF, StallD, StallE and FlushM; decrement cnt; ignore PCSrcE, MdStartE and load-use.
REQ-019 BUSY with cnt==0: all stalls and flushes SHALL be deasserted, MdDoneE=1, and the FSM returns to IDLE next cycle.
REQ-020 Stall cycles per mul/div op SHALL total exactly MD_LATENCY-1, and MdDoneE SHALL fire in the MD_LATENCY-th cycle.
REQ-021 Back-to-back mul/div ops: MdStartE high in the IDLE cycle after MdDoneE SHALL start a new op per REQ-016.
REQ-022 All outputs SHALL be combinational from state, cnt and inputs; no output is registered.

Reset
REQ-023 While reset=1 all outputs SHALL be 0.
REQ-024 The clock edge with reset=1 SHALL set state to IDLE and cnt to 0.
REQ-025 Reset asserted in BUSY SHALL abort the op, and MdDoneE SHALL not fire for it.

Configuration
REQ-026 With macro HAZ_PERF_CNT_EN defined, the block SHALL add three outputs:
- LoadUseCnt, MdStallCnt, FlushCnt  out  32 each.
- Each is a saturating count of cycles with a load-use stall, a mul/div stall (REQ-016/018) and PCSrcE flushes respectively.
- All three are cleared by reset.
REQ-027 Without HAZ_PERF_CNT_EN the three ports and their counters SHALL not exist, and the remaining behaviour SHALL be identical.

Structure
REQ-028 Package hazard_pkg SHALL hold:
- the hz_state_t enum (IDLE, BUSY);
- the MD_LATENCY default constant;
- PERF_CNT_W=32.
REQ-029 The counters SHALL live in sub-module hazard_perf_counters, which is instantiated only under HAZ_PERF_CNT_EN.

Verification
REQ-030 Load-use: RdE=5, ResultSrcE0=1, Rs1D=5 -> StallF=StallD=FlushE=1 for 1 cycle; same stimulus with RdE=0 -> no stall.
REQ-031 Taken branch: PCSrcE=1 in IDLE -> FlushD=FlushE=1 and no stalls; with MdStartE=1 in the same cycle -> still flush only, MdBusy stays 0.
REQ-032 Mul/div, MD_LATENCY=4: MdStartE held high -> stalls and FlushM high for cycles 0-2, MdDoneE=1 in cycle 3, IDLE in cycle 4.
REQ-033 Mul/div plus concurrent load-use in the start cycle -> FlushE=0 and stalls per REQ-016.
REQ-034 Reset in the 2nd BUSY cycle -> all outputs 0 while reset is high, IDLE afterwards, no MdDoneE.
REQ-035 With HAZ_PERF_CNT_EN: 2 load-use events, one MD_LATENCY=4 op and 1 branch -> LoadUseCnt=2, MdStallCnt=3, FlushCnt=1.
